// File: rtl/gate_sweep_pkg.sv
// Shared types for the gate sweep checker: reference-function modes,
// sequencer states and the legal-mode test.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_NAND = 3'd1,
        MODE_OR   = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_ILL6 = 3'd6,
        MODE_ILL7 = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_legal_mode(input logic [2:0] mode);
        return mode <= 3'd5;
    endfunction

endpackage

// File: rtl/gate_ref.sv
// Golden reduction function for an N-input gate; combinational, reusable
// anywhere a reference response for (mode, vector) is needed.
module gate_ref
    import gate_sweep_pkg::*;
#(
    parameter int N_INPUTS = 2
) (
    input  logic [2:0]          i_mode,
    input  logic [N_INPUTS-1:0] i_vec,
    output logic                o_expected
);

    always_comb begin
        o_expected = 1'b0;
        case (mode_e'(i_mode))
            MODE_AND:  o_expected = &i_vec;
            MODE_NAND: o_expected = ~&i_vec;
            MODE_OR:   o_expected = |i_vec;
            MODE_NOR:  o_expected = ~|i_vec;
            MODE_XOR:  o_expected = ^i_vec;
            MODE_XNOR: o_expected = ~^i_vec;
            default:   o_expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of an N-input gate: drives every vector, holds it for the
// DUT latency, compares against gate_ref and reports mismatch statistics.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_INPUTS    = 2,
    parameter int DUT_LATENCY = 0,
    parameter int ERR_W       = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [2:0]          i_mode,
    output logic [N_INPUTS-1:0] o_stim,
    input  logic                i_dut_r,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_mode_err,
    output logic [ERR_W-1:0]    o_err_count,
    output logic                o_first_err_valid,
    output logic [N_INPUTS-1:0] o_first_err_vec
);

    localparam logic [1:0]          LAST_HOLD = 2'(DUT_LATENCY);
    localparam logic [N_INPUTS-1:0] LAST_VEC  = '1;
    localparam logic [ERR_W-1:0]    ERR_MAX   = '1;

    state_e              r_state, w_next;
    logic [2:0]          r_mode;
    logic [N_INPUTS-1:0] r_stim;
    logic [1:0]          r_hold;
    logic [ERR_W-1:0]    r_err;
    logic                r_first_valid;
    logic [N_INPUTS-1:0] r_first_vec;
    logic                r_pass;
    logic                r_mode_err;

    logic                w_expected;
    logic                w_accept;
    logic                w_legal;
    logic                w_check;
    logic                w_last;
    logic                w_miss;
    logic [ERR_W-1:0]    w_err_nx;

    gate_ref #(.N_INPUTS(N_INPUTS)) u_ref (
        .i_mode     (r_mode),
        .i_vec      (r_stim),
        .o_expected (w_expected)
    );

    assign w_accept = i_start && (r_state != S_RUN);
    assign w_legal  = is_legal_mode(i_mode);
    // The check lands on the edge that ends the last hold cycle of a vector.
    assign w_check  = (r_state == S_RUN) && (r_hold == LAST_HOLD);
    assign w_last   = w_check && (r_stim == LAST_VEC);
    assign w_miss   = w_check && (i_dut_r != w_expected);
    assign w_err_nx = (w_miss && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = w_legal ? S_RUN : S_DONE;
            S_RUN:          if (w_last)  w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode        <= '0;
            r_stim        <= '0;
            r_hold        <= '0;
            r_err         <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_pass        <= 1'b0;
            r_mode_err    <= 1'b0;
        end else if (w_accept) begin
            r_mode        <= i_mode;
            r_stim        <= '0;
            r_hold        <= '0;
            r_err         <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_pass        <= 1'b0;
            r_mode_err    <= !w_legal;
        end else if (r_state == S_RUN) begin
            if (w_check) begin
                r_err  <= w_err_nx;
                r_stim <= r_stim + 1'b1;
                r_hold <= '0;
                if (w_miss && !r_first_valid) begin
                    r_first_valid <= 1'b1;
                    r_first_vec   <= r_stim;
                end
                if (w_last) r_pass <= (w_err_nx == '0);
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_stim            = r_stim;
    assign o_busy            = (r_state == S_RUN);
    assign o_done            = (r_state == S_DONE);
    assign o_pass            = r_pass;
    assign o_mode_err        = r_mode_err;
    assign o_err_count       = r_err;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_vec   = r_first_vec;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Parametrised, synthesisable successor to the fixed two-input gate truth-table check. It sweeps every input combination of an N-input combinational (or pipelined) gate DUT, compares each response against a selectable reference function, counts mismatches and reports pass/fail. It sits beside any gate under test in lab benches and on-board self-test, replacing hand-written stimulus sequences.

Parameters:
N_INPUTS, 2, DUT input width (1..8); sweep covers 2^N_INPUTS vectors.
DUT_LATENCY, 0, clock cycles between stim change and valid dut_r (0..3).
ERR_W, 8, width of the error counter (saturating).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
mode  input  3  reference function; latched at accepted start
stim  output  N_INPUTS  vector driven to DUT
dut_r  input  1  DUT response
busy  output  1  sweep in progress
done  output  1  sweep finished; level, held until next accepted start
pass  output  1  done && err_count==0 && !mode_err
mode_err  output  1  latched mode was illegal (6 or 7)
err_count  output  ERR_W  mismatch count, saturating at 2^ERR_W-1
first_err_valid  output  1  at least one mismatch recorded
first_err_vec  output  N_INPUTS  stim value of first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; stim=0, busy=0, done=0, pass=0, mode_err=0, err_count=0, first_err_valid=0, first_err_vec=0. Reset mid-sweep aborts immediately; no partial results retained.
- Mode encoding: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR (reductions over stim); 6/7 illegal. N_INPUTS=1: AND/OR/XOR = stim[0], NAND/NOR/XNOR = ~stim[0].
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge: legal mode -> RUN; stim=0, hold counter=0, busy=1, done=0, pass=0, err_count=0, first_err_*=0, mode latched. Illegal mode -> DONE next cycle, mode_err=1, pass=0, err_count=0, busy never asserts.
- RUN: each vector held DUT_LATENCY+1 cycles. On the edge ending the final hold cycle, dut_r is compared with ref(mode_latched, stim); mismatch increments err_count (saturating) and, if first_err_valid=0, captures first_err_vec=stim and sets first_err_valid. Same edge: stim increments, hold counter clears.
- After the check of vector 2^N_INPUTS-1: -> DONE; busy=0, done=1, pass computed same edge; stim wraps to 0. busy high for exactly 2^N_INPUTS*(DUT_LATENCY+1) cycles.
- start while RUN: ignored. mode changes while RUN: ignored.
- DONE: results stable until start or reset; start in DONE restarts exactly as from IDLE.
- All outputs registered; no combinational path from dut_r to any output.

Decomposition:
- Package gate_sweep_pkg: mode enum (MODE_AND..MODE_XNOR, illegal 6/7), state enum (S_IDLE, S_RUN, S_DONE), function is_legal_mode.
- Sub-module gate_ref: combinational, parameter N_INPUTS; inputs mode, vec; output expected. Instantiated once; also reusable by benches as the golden model.

Test Plan:
1. N_INPUTS=2, DUT_LATENCY=0, mode=1 (NAND), DUT = and_gate+not_gate chain on stim -> busy 4 cycles, stim 0,1,2,3, done=1, err_count=0, pass=1.
2. Same DUT, mode=0 (AND) -> err_count=4, first_err_valid=1, first_err_vec=2'b00, pass=0.
3. N_INPUTS=3, DUT_LATENCY=2, mode=4, XOR DUT delayed 2 cycles -> busy 24 cycles, pass=1; delay DUT by 1 cycle instead -> err_count>0, pass=0.
4. ERR_W=2, N_INPUTS=3, mode=0, DUT = constant ~AND -> err_count saturates at 3, first_err_vec=3'b000.
5. Assert rst_n low while stim=2 mid-sweep -> all outputs at reset values within the same cycle; new start completes a full sweep with correct results.
6. mode=7 with start -> no busy, done=1 and mode_err=1 next cycle, pass=0; start pulses during a legal RUN -> ignored, sweep length unchanged.
